// File: rtl/split_bus_arbiter.sv
// split_bus_arbiter: round-robin bus arbiter that parks split transactions and
// re-grants the parked initiator on split_req_i, with a stall watchdog.
module split_bus_arbiter #(
  parameter int NUM_INIT       = 2,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int IDXW = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1,
  localparam int CW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_INIT-1:0] init_req_i,
  output logic [NUM_INIT-1:0] init_grant_o,
  input  logic                bus_ack_i,
  input  logic                bus_split_ack_i,
  input  logic                split_req_i,
  output logic                split_grant_o,
  output logic                bus_busy_o,
  output logic [IDXW-1:0]     grant_idx_o,
  output logic                split_pending_o,
  output logic [IDXW-1:0]     split_owner_o,
  output logic                timeout_o,
  output logic                protocol_err_o
);
  typedef enum logic [1:0] {IDLE, BUSY, SPLIT} state_t;
  state_t              state_q;
  logic [NUM_INIT-1:0] init_grant_q, elig;
  logic [IDXW-1:0]     grant_idx_q, split_owner_q, last_q, win, idx;
  logic [CW-1:0]       cnt_q;
  logic                split_grant_q, bus_busy_q, split_pending_q, timeout_q, protocol_err_q;
  logic                wd_fire;
  assign init_grant_o    = init_grant_q;
  assign split_grant_o   = split_grant_q;
  assign bus_busy_o      = bus_busy_q;
  assign grant_idx_o     = grant_idx_q;
  assign split_pending_o = split_pending_q;
  assign split_owner_o   = split_owner_q;
  assign timeout_o       = timeout_q;
  assign protocol_err_o  = protocol_err_q;
  assign wd_fire = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1)) && !bus_ack_i;
  // Descending scan so the closest set bit after last_q is the final winner.
  always_comb begin
    elig = init_req_i;
    if (split_pending_q) elig[split_owner_q] = 1'b0;
    win = '0;
    idx = '0;
    for (int k = NUM_INIT; k >= 1; k--) begin
      idx = IDXW'((int'(last_q) + k) % NUM_INIT);
      if (elig[idx]) win = idx;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      init_grant_q    <= '0;
      split_grant_q   <= 1'b0;
      bus_busy_q      <= 1'b0;
      grant_idx_q     <= '0;
      split_pending_q <= 1'b0;
      split_owner_q   <= '0;
      timeout_q       <= 1'b0;
      protocol_err_q  <= 1'b0;
      last_q          <= IDXW'(NUM_INIT - 1);
      cnt_q           <= '0;
    end else begin
      timeout_q      <= 1'b0;
      protocol_err_q <= 1'b0;
      cnt_q          <= cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (split_pending_q && split_req_i) begin
            state_q       <= SPLIT;
            split_grant_q <= 1'b1;
            bus_busy_q    <= 1'b1;
            init_grant_q  <= NUM_INIT'(1) << split_owner_q;
            grant_idx_q   <= split_owner_q;
          end else if (|elig) begin
            state_q      <= BUSY;
            bus_busy_q   <= 1'b1;
            init_grant_q <= NUM_INIT'(1) << win;
            grant_idx_q  <= win;
            last_q       <= win;
          end
        end
        BUSY: begin
          if (bus_ack_i || bus_split_ack_i || !init_req_i[grant_idx_q] || wd_fire) begin
            state_q      <= IDLE;
            bus_busy_q   <= 1'b0;
            init_grant_q <= '0;
          end
          if (!bus_ack_i && bus_split_ack_i) begin
            if (split_pending_q) protocol_err_q <= 1'b1;
            else begin
              split_pending_q <= 1'b1;
              split_owner_q   <= grant_idx_q;
            end
          end else if (init_req_i[grant_idx_q] && wd_fire) timeout_q <= 1'b1;
        end
        SPLIT: begin
          protocol_err_q <= bus_split_ack_i;
          timeout_q      <= wd_fire;
          if (bus_ack_i || wd_fire) begin
            state_q         <= IDLE;
            bus_busy_q      <= 1'b0;
            split_grant_q   <= 1'b0;
            init_grant_q    <= '0;
            split_pending_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_split_bus_arbiter.sv
// tb_split_bus_arbiter: directed and random stimulus checked every cycle
// against a transaction-level model of the arbiter.
module tb_split_bus_arbiter;
  localparam int N = 2;
  localparam int T = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic ack = 1'b0, sack = 1'b0, sreq = 1'b0;
  logic [N-1:0] grant;
  logic sgrant, busy, gidx, pend, sown, to, pe;
  int total = 0, bad = 0;
  int m_owner, m_last, m_held, m_gidx, m_sown;
  bit m_split, m_pend, m_to, m_pe;

  split_bus_arbiter #(.NUM_INIT(N), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .init_req_i(req), .init_grant_o(grant),
    .bus_ack_i(ack), .bus_split_ack_i(sack), .split_req_i(sreq),
    .split_grant_o(sgrant), .bus_busy_o(busy), .grant_idx_o(gidx),
    .split_pending_o(pend), .split_owner_o(sown), .timeout_o(to),
    .protocol_err_o(pe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_owner = -1; m_last = N - 1; m_held = 0; m_gidx = 0; m_sown = 0;
    m_split = 0; m_pend = 0; m_to = 0; m_pe = 0;
  endtask

  // One bus cycle of the model: owner -1 means the bus is idle.
  task automatic m_step();
    m_to = 0; m_pe = 0;
    if (m_owner < 0) begin
      if (m_pend && sreq) begin
        m_owner = m_sown; m_split = 1; m_gidx = m_sown; m_held = 1;
      end else begin
        for (int k = 1; k <= N; k++) begin
          int i;
          i = (m_last + k) % N;
          if (req[i] && !(m_pend && i == m_sown)) begin
            m_owner = i; m_split = 0; m_gidx = i; m_last = i; m_held = 1;
            break;
          end
        end
      end
    end else if (!m_split) begin
      if (ack) m_owner = -1;
      else if (sack) begin
        if (m_pend) m_pe = 1;
        else begin m_pend = 1; m_sown = m_gidx; end
        m_owner = -1;
      end else if (!req[m_owner]) m_owner = -1;
      else if (m_held == T) begin m_to = 1; m_owner = -1; end
      else m_held++;
    end else begin
      if (sack) m_pe = 1;
      if (ack) begin m_pend = 0; m_owner = -1; end
      else if (m_held == T) begin m_to = 1; m_pend = 0; m_owner = -1; end
      else m_held++;
    end
  endtask

  task automatic check_all();
    chk("init_grant", grant, (m_owner < 0) ? 0 : (1 << m_owner));
    chk("split_grant", sgrant, (m_owner >= 0 && m_split) ? 1 : 0);
    chk("bus_busy", busy, (m_owner >= 0) ? 1 : 0);
    chk("grant_idx", gidx, m_gidx);
    chk("split_pending", pend, m_pend);
    chk("split_owner", sown, m_sown);
    chk("timeout", to, m_to);
    chk("protocol_err", pe, m_pe);
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic a, input logic s, input logic q);
    req = r; ack = a; sack = s; sreq = q;
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    m_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    // Round robin with ack in the fourth grant cycle
    for (int i = 0; i < 4; i++) begin
      cyc(2'b11, 0, 0, 0);
      chk("rr_grant", grant, (i % 2 == 0) ? 1 : 2);
      cyc(2'b11, 0, 0, 0);
      cyc(2'b11, 0, 0, 0);
      cyc(2'b11, 1, 0, 0);
      chk("rr_turnaround", grant, 0);
    end
    // Split park, other initiator served, split return
    cyc(2'b11, 0, 0, 0);
    cyc(2'b11, 0, 1, 0);
    chk("park_pending", pend, 1);
    chk("park_owner", sown, 0);
    cyc(2'b11, 0, 0, 0);
    chk("masked_grant", grant, 2);
    cyc(2'b11, 1, 0, 0);
    cyc(2'b00, 0, 0, 1);
    chk("ret_split_grant", sgrant, 1);
    chk("ret_init_grant", grant, 1);
    cyc(2'b00, 1, 0, 0);
    chk("ret_cleared", pend, 0);
    // Simultaneous ack and split ack is a plain completion
    cyc(2'b01, 0, 0, 0);
    cyc(2'b01, 1, 1, 0);
    chk("both_pending", pend, 0);
    chk("both_release", grant, 0);
    // Second split while one is pending
    cyc(2'b10, 0, 0, 0);
    cyc(2'b10, 0, 1, 0);
    cyc(2'b11, 0, 0, 0);
    chk("second_grant", grant, 1);
    cyc(2'b11, 0, 1, 0);
    chk("second_perr", pe, 1);
    chk("second_owner", sown, 1);
    chk("second_release", grant, 0);
    // Watchdog in BUSY
    for (int k = 1; k <= 4; k++) begin
      cyc(2'b01, 0, 0, 0);
      chk("wd_busy_held", grant, 1);
    end
    cyc(2'b01, 0, 0, 0);
    chk("wd_busy_timeout", to, 1);
    chk("wd_busy_release", grant, 0);
    cyc(2'b00, 0, 0, 0);
    chk("wd_busy_pulse", to, 0);
    // Watchdog in SPLIT
    for (int k = 1; k <= 4; k++) begin
      cyc(2'b00, 0, 0, 1);
      chk("wd_split_held", sgrant, 1);
    end
    cyc(2'b00, 0, 0, 1);
    chk("wd_split_timeout", to, 1);
    chk("wd_split_pending", pend, 0);
    cyc(2'b00, 0, 0, 0);
    // Asynchronous reset during SPLIT
    cyc(2'b10, 0, 0, 0);
    cyc(2'b10, 0, 1, 0);
    cyc(2'b00, 0, 0, 1);
    chk("pre_reset_split", sgrant, 1);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("rst_grant", grant, 0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2'b11, 0, 0, 0);
    chk("post_reset_first", grant, 1);
    // Random traffic
    for (int n = 0; n < 1500; n++)
      cyc(N'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
